// File: rtl/coin_acceptor.sv
// Coin-sensor front end: sync + debounce per line, single-coin validation, coin FIFO and paced
// one-cycle pulse outputs. Define COIN_ACCEPTOR_TOTAL_EN to add the saturating o_total_cents port.
`timescale 1ns/1ps
module coin_acceptor #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int GAP_CYC      = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_nickel_raw,
   input  logic                         i_dime_raw,
   input  logic                         i_quarter_raw,
   output logic                         o_nickel,
   output logic                         o_dime,
   output logic                         o_quarter,
   output logic                         o_reject,
   output logic                         o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]  o_level
`ifdef COIN_ACCEPTOR_TOTAL_EN
   ,
   output logic [9:0]                   o_total_cents
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam int GW = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);
   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_QUARTER = 2'b11
   } coin_e;

   logic [2:0]    raw, sync_q1, sync_q2, filt, filt_d, rise;
   logic          jam, jam_q, pop, push_ok, drop;
   coin_e         push_code, head;
   coin_e         mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, level;
   logic [GW-1:0] gap;

   assign raw = {i_quarter_raw, i_dime_raw, i_nickel_raw};

   // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

   for (genvar l = 0; l < 3; l++) begin : g_line
      logic          state;
      logic [CW-1:0] cnt;
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            state <= 1'b0;
            cnt   <= '0;
         end else if (sync_q2[l] == state) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            state <= ~state;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
      assign filt[l] = state;
   end

   assign rise = filt & ~filt_d;
   assign jam  = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);

   // NOTE: combinational outputs get a default first so no path can infer a latch.
   always_comb begin
      push_code = COIN_NONE;
      case (rise)
         3'b001:  push_code = COIN_NICKEL;
         3'b010:  push_code = COIN_DIME;
         3'b100:  push_code = COIN_QUARTER;
         default: push_code = COIN_NONE;
      endcase
   end

   // Pop is decided from the registered level, so a full FIFO that is popping still accepts.
   assign level   = wr_ptr - rd_ptr;
   assign pop     = (level != '0) && (gap == '0);
   assign push_ok = (push_code != COIN_NONE) && ((level != FULL_LEVEL) || pop);
   assign drop    = (push_code != COIN_NONE) && (level == FULL_LEVEL) && !pop;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign o_level = level;

   // NOTE: the storage array has no reset; pointers alone decide which entries are valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_code;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         filt_d     <= '0;
         jam_q      <= 1'b0;
         o_reject   <= 1'b0;
         o_overflow <= 1'b0;
         o_nickel   <= 1'b0;
         o_dime     <= 1'b0;
         o_quarter  <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         gap        <= '0;
      end else begin
         filt_d    <= filt;
         jam_q     <= jam;
         o_reject  <= jam_q;
         o_nickel  <= pop && (head == COIN_NICKEL);
         o_dime    <= pop && (head == COIN_DIME);
         o_quarter <= pop && (head == COIN_QUARTER);
         if (drop)    o_overflow <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            gap    <= GW'(GAP_CYC);
         end else if (gap != '0) begin
            gap <= gap - 1'b1;
         end
      end
   end

`ifdef COIN_ACCEPTOR_TOTAL_EN
   logic [10:0] coin_cents, total_sum;

   always_comb begin
      coin_cents = 11'd0;
      case (head)
         COIN_NICKEL:  coin_cents = 11'd5;
         COIN_DIME:    coin_cents = 11'd10;
         COIN_QUARTER: coin_cents = 11'd25;
         default:      coin_cents = 11'd0;
      endcase
   end

   assign total_sum = {1'b0, o_total_cents} + coin_cents;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)    o_total_cents <= '0;
      else if (pop) o_total_cents <= (total_sum > 11'd1023) ? 10'd1023 : total_sum[9:0];
   end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: three instances (gap 1, 8, 60) share the raw lines and are compared
// every cycle against a cycle-level model, plus directed timing/queue/reset/total checks.
`timescale 1ns/1ps
module tb_coin_acceptor;
   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic raw_n = 1'b0, raw_d = 1'b0, raw_q = 1'b0;

   logic       o_n [3];
   logic       o_d [3];
   logic       o_q [3];
   logic       o_rej [3];
   logic       o_ovf [3];
   logic [2:0] o_lvl [3];
`ifdef COIN_ACCEPTOR_TOTAL_EN
   logic [9:0] o_tot [3];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      coin_acceptor #(
         .DEBOUNCE_CYC (D),
         .FIFO_DEPTH   (DEPTH),
         .GAP_CYC      ((g == 0) ? 1 : ((g == 1) ? 8 : 60))
      ) dut (
         .i_clk         (clk),
         .i_rst         (rst),
         .i_nickel_raw  (raw_n),
         .i_dime_raw    (raw_d),
         .i_quarter_raw (raw_q),
         .o_nickel      (o_n[g]),
         .o_dime        (o_d[g]),
         .o_quarter     (o_q[g]),
         .o_reject      (o_rej[g]),
         .o_overflow    (o_ovf[g]),
         .o_level       (o_lvl[g])
`ifdef COIN_ACCEPTOR_TOTAL_EN
         ,
         .o_total_cents (o_tot[g])
`endif
      );
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // ---------------- reference model ----------------
   bit [2:0] m_s1, m_s2, m_f, m_fd;
   int       m_cnt [3];
   bit       m_jam;
   int       m_q [3][DEPTH];   // queued coin values in cents, index 0 is oldest
   int       m_n [3];
   int       m_gap [3];
   int       m_tot [3];
   bit       e_n [3], e_d [3], e_q [3], e_rej [3], e_ovf [3];

   function automatic int gap_of(int i);
      return (i == 0) ? 1 : ((i == 1) ? 8 : 60);
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_f = '0; m_fd = '0; m_jam = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_n[i] = 0; m_gap[i] = 0; m_tot[i] = 0;
         e_n[i] = 0; e_d[i] = 0; e_q[i] = 0; e_rej[i] = 0; e_ovf[i] = 0;
      end
   endtask

   task automatic model_step();
      bit [2:0] rise;
      int nev, val, head;
      rise = m_f & ~m_fd;
      nev  = $countones(rise);
      val  = rise[0] ? 5 : (rise[1] ? 10 : 25);
      for (int i = 0; i < 3; i++) begin
         e_n[i] = 0; e_d[i] = 0; e_q[i] = 0;
         if (m_n[i] > 0 && m_gap[i] == 0) begin
            head   = m_q[i][0];
            e_n[i] = (head == 5);
            e_d[i] = (head == 10);
            e_q[i] = (head == 25);
            m_tot[i] = (m_tot[i] + head > 1023) ? 1023 : m_tot[i] + head;
            for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
            m_n[i]   = m_n[i] - 1;
            m_gap[i] = gap_of(i);
         end else if (m_gap[i] > 0) begin
            m_gap[i] = m_gap[i] - 1;
         end
         if (nev == 1) begin
            if (m_n[i] < DEPTH) begin
               m_q[i][m_n[i]] = val;
               m_n[i] = m_n[i] + 1;
            end else begin
               e_ovf[i] = 1;
            end
         end
         e_rej[i] = m_jam;
      end
      m_jam = (nev >= 2);
      m_fd  = m_f;
      for (int l = 0; l < 3; l++) begin
         if (m_s2[l] != m_f[l]) begin
            m_cnt[l] = m_cnt[l] + 1;
            if (m_cnt[l] == D) begin
               m_f[l]   = ~m_f[l];
               m_cnt[l] = 0;
            end
         end else begin
            m_cnt[l] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = {raw_q, raw_d, raw_n};
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] cyc=%0d: observed=%0d expected=%0d", tag, inst, cyc, obs, exp);
      end
   endtask

   int cnt_n [3], cnt_d [3], cnt_q [3], cnt_rej [3], max_lvl [3];
   bit track_gap = 0;
   int last_q2   = -1;

   task automatic clear_counts();
      for (int i = 0; i < 3; i++) begin
         cnt_n[i] = 0; cnt_d[i] = 0; cnt_q[i] = 0; cnt_rej[i] = 0; max_lvl[i] = 0;
      end
      last_q2 = -1;
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         check("nickel",   i, 32'(o_n[i]),   32'(e_n[i]));
         check("dime",     i, 32'(o_d[i]),   32'(e_d[i]));
         check("quarter",  i, 32'(o_q[i]),   32'(e_q[i]));
         check("reject",   i, 32'(o_rej[i]), 32'(e_rej[i]));
         check("overflow", i, 32'(o_ovf[i]), 32'(e_ovf[i]));
         check("level",    i, 32'(o_lvl[i]), m_n[i]);
`ifdef COIN_ACCEPTOR_TOTAL_EN
         check("total",    i, 32'(o_tot[i]), m_tot[i]);
`endif
         cnt_n[i]   += int'(o_n[i]);
         cnt_d[i]   += int'(o_d[i]);
         cnt_q[i]   += int'(o_q[i]);
         cnt_rej[i] += int'(o_rej[i]);
         if (int'(o_lvl[i]) > max_lvl[i]) max_lvl[i] = int'(o_lvl[i]);
      end
      if (o_q[2] === 1'b1) begin
         if (track_gap && last_q2 >= 0) check("gap60_spacing", 2, cyc - last_q2, 61);
         last_q2 = cyc;
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check_all();
   endtask

   // Called at a falling edge; pulses reset between edges and checks outputs while it is high.
   task automatic apply_reset();
      raw_n = 1'b0; raw_d = 1'b0; raw_q = 1'b0;
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_nickel",   i, 32'(o_n[i]),   0);
         check("rst_dime",     i, 32'(o_d[i]),   0);
         check("rst_quarter",  i, 32'(o_q[i]),   0);
         check("rst_reject",   i, 32'(o_rej[i]), 0);
         check("rst_overflow", i, 32'(o_ovf[i]), 0);
         check("rst_level",    i, 32'(o_lvl[i]), 0);
`ifdef COIN_ACCEPTOR_TOTAL_EN
         check("rst_total",    i, 32'(o_tot[i]), 0);
`endif
      end
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic set_line(input int l, input logic v);
      if (l == 0) raw_n = v;
      else if (l == 1) raw_d = v;
      else raw_q = v;
   endtask

   task automatic insert_coin(input int l, input int hi, input int lo);
      set_line(l, 1'b1);
      repeat (hi) cycle();
      set_line(l, 1'b0);
      repeat (lo) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_k;
      int hold [3];
      bit [2:0] rv;

      model_reset();
      clear_counts();
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("init_level",    i, 32'(o_lvl[i]), 0);
         check("init_overflow", i, 32'(o_ovf[i]), 0);
         check("init_quarter",  i, 32'(o_q[i]),   0);
      end
      rst = 1'b0;
      model_reset();

      // Single dime held 20 cycles: pulse only in the cycle after edge 7.
      clear_counts();
      first_k = -1;
      raw_d = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (o_d[0] === 1'b1 && first_k < 0) first_k = k;
      end
      raw_d = 1'b0;
      repeat (10) cycle();
      check("dime_edge", 0, first_k, 7);
      check("dime_count", 0, cnt_d[0], 1);
      check("dime_other", 0, cnt_n[0] + cnt_q[0] + cnt_rej[0], 0);

      // Bouncing nickel, then held high: one pulse 7 cycles after the final rise.
      clear_counts();
      for (int r = 0; r < 3; r++) begin
         raw_n = 1'b1; repeat (2) cycle();
         raw_n = 1'b0; repeat (2) cycle();
      end
      first_k = -1;
      raw_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (o_n[0] === 1'b1 && first_k < 0) first_k = k;
      end
      raw_n = 1'b0;
      repeat (10) cycle();
      check("bounce_edge", 0, first_k, 7);
      check("bounce_count", 0, cnt_n[0], 1);

      // Nickel and quarter together: jam, reject after edge 7, nothing queued.
      clear_counts();
      first_k = -1;
      raw_n = 1'b1; raw_q = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (o_rej[0] === 1'b1 && first_k < 0) first_k = k;
      end
      raw_n = 1'b0; raw_q = 1'b0;
      repeat (10) cycle();
      check("jam_edge", 0, first_k, 7);
      check("jam_count", 0, cnt_rej[0], 1);
      check("jam_coins", 0, cnt_n[0] + cnt_d[0] + cnt_q[0], 0);
      check("jam_level", 0, 32'(o_lvl[0]), 0);

      // Six quarters 10 cycles apart: gap 8 keeps up, gap 60 fills and overflows.
      @(negedge clk);
      apply_reset();
      clear_counts();
      track_gap = 1;
      for (int c = 0; c < 6; c++) insert_coin(2, 5, 5);
      repeat (300) cycle();
      track_gap = 0;
      check("q_count_g1", 0, cnt_q[0], 6);
      check("q_count_g8", 1, cnt_q[1], 6);
      check("q_ovf_g8", 1, 32'(o_ovf[1]), 0);
      check("q_count_g60", 2, cnt_q[2], 5);
      check("q_ovf_g60", 2, 32'(o_ovf[2]), 1);
      check("q_maxlvl_g60", 2, max_lvl[2], 4);

      // Three coins queued in the gap-60 instance, then an asynchronous reset mid-cycle.
      for (int c = 0; c < 4; c++) insert_coin(2, 5, 5);
      check("pre_rst_level", 2, 32'(o_lvl[2]), 3);
      apply_reset();
      clear_counts();
      repeat (80) cycle();
      for (int i = 0; i < 3; i++)
         check("post_rst_pulses", i, cnt_n[i] + cnt_d[i] + cnt_q[i] + cnt_rej[i], 0);

`ifdef COIN_ACCEPTOR_TOTAL_EN
      // Running total: 25, 35, 40, then saturation at 1023.
      apply_reset();
      insert_coin(2, 5, 6);
      check("total_q", 0, 32'(o_tot[0]), 25);
      insert_coin(1, 5, 6);
      check("total_qd", 0, 32'(o_tot[0]), 35);
      insert_coin(0, 5, 6);
      check("total_qdn", 0, 32'(o_tot[0]), 40);
      for (int c = 0; c < 41; c++) insert_coin(2, 5, 6);
      check("total_sat", 0, 32'(o_tot[0]), 1023);
`endif

      // Random raw activity on all lines, compared cycle by cycle with the model.
      apply_reset();
      for (int l = 0; l < 3; l++) hold[l] = 0;
      rv = '0;
      for (int c = 0; c < 900; c++) begin
         for (int l = 0; l < 3; l++) begin
            if (hold[l] == 0) begin
               rv[l]   = 1'($urandom_range(0, 1));
               hold[l] = int'($urandom_range(1, 12));
            end else begin
               hold[l] = hold[l] - 1;
            end
         end
         raw_n = rv[0]; raw_d = rv[1]; raw_q = rv[2];
         cycle();
      end
      raw_n = 1'b0; raw_d = 1'b0; raw_q = 1'b0;
      repeat (300) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
